// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: forwarding select encoding and the hazard tracking entry.
package cpu_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
    logic       setflag;
  } trk_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational compare of one tracked stage against a read register; X31 never matches.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NREG  = 32
) (
  input  trk_entry_t       entry,
  input  logic [REG_W-1:0] reg_idx,
  output logic             hit
);

  assign hit = entry.valid & entry.regwrite & (entry.rd == reg_idx) &
               (reg_idx != REG_W'(NREG - 1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: stall, bubble, operand and flag forwarding.
// Optional build macro HAZARD_PERF_EN adds saturating stall/forward performance counters.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rf_valid,
  input  logic [REG_W-1:0] rf_rn,
  input  logic [REG_W-1:0] rf_rb,
  input  logic             rf_uses_rn,
  input  logic             rf_uses_rb,
  input  logic [REG_W-1:0] rf_rd,
  input  logic             rf_regwrite,
  input  logic             rf_load,
  input  logic             rf_setflag,
  input  logic             rf_uses_flags,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_fwd_cnt,
`endif
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_flags
);

  trk_entry_t ex_r, mem_r, wb_r;
  trk_entry_t rf_entry_s;
  fwd_sel_e   sel_a_s, sel_b_s;
  logic       ex_a_s, mem_a_s, ex_b_s, mem_b_s;
  logic       unused_s;

  hazard_match #(.REG_W(REG_W), .NREG(NREG)) u_match_ex_a  (.entry(ex_r),  .reg_idx(rf_rn), .hit(ex_a_s));
  hazard_match #(.REG_W(REG_W), .NREG(NREG)) u_match_mem_a (.entry(mem_r), .reg_idx(rf_rn), .hit(mem_a_s));
  hazard_match #(.REG_W(REG_W), .NREG(NREG)) u_match_ex_b  (.entry(ex_r),  .reg_idx(rf_rb), .hit(ex_b_s));
  hazard_match #(.REG_W(REG_W), .NREG(NREG)) u_match_mem_b (.entry(mem_r), .reg_idx(rf_rb), .hit(mem_b_s));

  // Stall, bubble and forwarding selects from RF decode and tracked state
  always_comb begin
    stall     = 1'b0;
    bubble    = 1'b0;
    sel_a_s   = FWD_RF;
    sel_b_s   = FWD_RF;
    fwd_flags = 1'b0;
    if (rf_valid) begin
      stall  = ex_r.valid & ex_r.load & ((rf_uses_rn & ex_a_s) | (rf_uses_rb & ex_b_s));
      bubble = stall;
      if (rf_uses_rn && ex_a_s) begin
        sel_a_s = FWD_EX;
      end else if (mem_a_s) begin
        sel_a_s = FWD_MEM;
      end else begin
        sel_a_s = FWD_RF;
      end
      if (rf_uses_rb && ex_b_s) begin
        sel_b_s = FWD_EX;
      end else if (mem_b_s) begin
        sel_b_s = FWD_MEM;
      end else begin
        sel_b_s = FWD_RF;
      end
      fwd_flags = rf_uses_flags & ex_r.valid & ex_r.setflag;
    end else begin
      stall = 1'b0;
    end
  end

  assign fwd_a = sel_a_s;
  assign fwd_b = sel_b_s;

  // RF attributes captured into EX; a stalled or empty RF slot enters as an invalid entry
  always_comb begin
    rf_entry_s = '0;
    if (rf_valid && !bubble) begin
      rf_entry_s.valid    = 1'b1;
      rf_entry_s.rd       = 5'(rf_rd);
      rf_entry_s.regwrite = rf_regwrite;
      rf_entry_s.load     = rf_load;
      rf_entry_s.setflag  = rf_setflag;
    end else begin
      rf_entry_s.valid = 1'b0;
    end
  end

  // Tracking pipe EX -> MEM -> WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      ex_r  <= rf_entry_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end
  end

  // The WB entry needs no forward (regfile writes on the falling edge); kept for debug visibility
  assign unused_s = ^wb_r;

`ifdef HAZARD_PERF_EN
  // Saturating stall and forward-activity counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 32'd0;
      perf_fwd_cnt   <= 32'd0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (((fwd_a != 2'd0) || (fwd_b != 2'd0)) && (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end else begin
        perf_fwd_cnt <= perf_fwd_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed test-plan sequences plus random instruction streams.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rn, rb;
    logic       urn, urb;
    logic [4:0] rd;
    logic       rw, ld, sf, uf;
  } ins_t;

  typedef struct {
    bit v;
    int rd;
    bit rw, ld, sf;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rf_valid = 1'b0;
  logic [4:0] rf_rn = 5'd0, rf_rb = 5'd0, rf_rd = 5'd0;
  logic       rf_uses_rn = 1'b0, rf_uses_rb = 1'b0;
  logic       rf_regwrite = 1'b0, rf_load = 1'b0, rf_setflag = 1'b0, rf_uses_flags = 1'b0;
  logic       stall, bubble, fwd_flags;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

  int   checks = 0;
  int   failures = 0;
  ent_t m[3];          // in-flight instructions: 0 = EX, 1 = MEM, 2 = WB
  int unsigned m_stall_cnt = 0, m_fwd_cnt = 0;

  pipeline_hazard_ctrl #(.REG_W(5), .NREG(32)) dut (
    .clk(clk), .reset(reset), .rf_valid(rf_valid),
    .rf_rn(rf_rn), .rf_rb(rf_rb), .rf_uses_rn(rf_uses_rn), .rf_uses_rb(rf_uses_rb),
    .rf_rd(rf_rd), .rf_regwrite(rf_regwrite), .rf_load(rf_load), .rf_setflag(rf_setflag),
    .rf_uses_flags(rf_uses_flags),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
    .stall(stall), .bubble(bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_flags(fwd_flags)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(int rn, int rb, bit urn, bit urb, int rd, bit rw, bit ld, bit sf, bit uf);
    ins_t i;
    i.v = 1'b1; i.rn = 5'(rn); i.rb = 5'(rb); i.urn = urn; i.urb = urb;
    i.rd = 5'(rd); i.rw = rw; i.ld = ld; i.sf = sf; i.uf = uf;
    return i;
  endfunction

  // Does the instruction tracked at position s write register r (X31 is never a dependency)?
  function automatic bit writes(int s, int r);
    return m[s].v && m[s].rw && (m[s].rd == r) && (r != 31);
  endfunction

  function automatic int src(bit v, bit uses, int r);
    if (!v) return 0;
    if (uses && writes(0, r)) return 1;
    if (writes(1, r)) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) m[k] = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0, sf: 1'b0};
    m_stall_cnt = 0;
    m_fwd_cnt = 0;
  endtask

  task automatic drive(input ins_t i);
    rf_valid = i.v; rf_rn = i.rn; rf_rb = i.rb; rf_uses_rn = i.urn; rf_uses_rb = i.urb;
    rf_rd = i.rd; rf_regwrite = i.rw; rf_load = i.ld; rf_setflag = i.sf; rf_uses_flags = i.uf;
  endtask

  // One pipeline cycle: drive, check on the falling edge, advance the model, then clock
  task automatic step(input ins_t i, output bit est);
    int ea, eb;
    bit eff;
    drive(i);
    @(negedge clk);
    ea  = src(i.v, i.urn, int'(i.rn));
    eb  = src(i.v, i.urb, int'(i.rb));
    est = i.v && m[0].v && m[0].ld &&
          ((i.urn && writes(0, int'(i.rn))) || (i.urb && writes(0, int'(i.rb))));
    eff = i.v && i.uf && m[0].v && m[0].sf;
    check_val("stall", 32'(stall), 32'(est));
    check_val("bubble", 32'(bubble), 32'(est));
    check_val("fwd_flags", 32'(fwd_flags), 32'(eff));
    if (!est) begin
      check_val("fwd_a", 32'(fwd_a), 32'(ea));
      check_val("fwd_b", 32'(fwd_b), 32'(eb));
    end
`ifdef HAZARD_PERF_EN
    check_val("perf_stall_cnt", perf_stall_cnt, 32'(m_stall_cnt));
    check_val("perf_fwd_cnt", perf_fwd_cnt, 32'(m_fwd_cnt));
`endif
    if (est) m_stall_cnt++;
    if (ea != 0 || eb != 0) m_fwd_cnt++;
    m[2] = m[1];
    m[1] = m[0];
    if (i.v && !est) m[0] = '{v: 1'b1, rd: int'(i.rd), rw: i.rw, ld: i.ld, sf: i.sf};
    else             m[0] = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0, sf: 1'b0};
    @(posedge clk);
    #1;
  endtask

  // Issue an instruction, re-presenting it while the model says the pipe is stalled
  task automatic issue(input ins_t i);
    bit st;
    int tries = 0;
    do begin
      step(i, st);
      tries++;
    end while (st && tries < 4);
    if (st) check_val("stall_bound", 32'd1, 32'd0);
  endtask

  ins_t nop, ri;
  int   pool[5] = '{0, 1, 2, 3, 31};
  bit   st;

  initial begin
    nop = '0;
    model_clear();
    #12;
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_fwd_a", 32'(fwd_a), 32'd0);
    check_val("rst_fwd_flags", 32'(fwd_flags), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(nop, st);

    // ADDS X1,X2,X3 ; ADD X4,X1,X5 ; ADD X6,X1,X7
    issue(mk(2, 3, 1, 1, 1, 1, 0, 1, 0));
    issue(mk(1, 5, 1, 1, 4, 1, 0, 0, 0));
    issue(mk(1, 7, 1, 1, 6, 1, 0, 0, 0));
    // LDUR X1 ; ADD X2,X1,X3 (one stall, then MEM forward)
    issue(mk(9, 31, 1, 0, 1, 1, 1, 0, 0));
    issue(mk(1, 3, 1, 1, 2, 1, 0, 0, 0));
    // ADD X1 ; SUB X1 ; consumer of X1 on both operands
    issue(mk(2, 3, 1, 1, 1, 1, 0, 0, 0));
    issue(mk(4, 5, 1, 1, 1, 1, 0, 0, 0));
    issue(mk(1, 1, 1, 1, 8, 1, 0, 0, 0));
    // ADD X31,X1,X2 ; CBZ X31
    issue(mk(1, 2, 1, 1, 31, 1, 0, 0, 0));
    issue(mk(31, 31, 0, 1, 31, 0, 0, 0, 0));
    // SUBS ; B.LT back to back, then with one instruction between
    issue(mk(1, 2, 1, 1, 0, 1, 0, 1, 0));
    issue(mk(31, 31, 0, 0, 31, 0, 0, 0, 1));
    issue(mk(1, 2, 1, 1, 0, 1, 0, 1, 0));
    issue(mk(3, 4, 1, 1, 5, 1, 0, 0, 0));
    issue(mk(31, 31, 0, 0, 31, 0, 0, 0, 1));

    // Random instruction streams over a small register pool
    for (int n = 0; n < 400; n++) begin
      ri.v   = ($urandom_range(0, 99) < 85);
      ri.rn  = 5'(pool[$urandom_range(0, 4)]);
      ri.rb  = 5'(pool[$urandom_range(0, 4)]);
      ri.rd  = 5'(pool[$urandom_range(0, 4)]);
      ri.urn = 1'($urandom_range(0, 1));
      ri.urb = 1'($urandom_range(0, 1));
      ri.rw  = ($urandom_range(0, 9) < 8);
      ri.ld  = ($urandom_range(0, 9) < 4);
      ri.sf  = 1'($urandom_range(0, 1));
      ri.uf  = 1'($urandom_range(0, 1));
      issue(ri);
    end

    // Reset asserted in the middle of a load-use stall
    issue(mk(9, 31, 1, 0, 1, 1, 1, 0, 0));
    drive(mk(1, 3, 1, 1, 2, 1, 0, 0, 0));
    @(negedge clk);
    check_val("pre_rst_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check_val("mid_rst_stall", 32'(stall), 32'd0);
    check_val("mid_rst_bubble", 32'(bubble), 32'd0);
    check_val("mid_rst_fwd_a", 32'(fwd_a), 32'd0);
    model_clear();
    drive(nop);
    @(posedge clk); #1;
    reset = 1'b1;
    step(nop, st);
    check_val("post_rst_fwd_b", 32'(fwd_b), 32'd0);

    for (int n = 0; n < 100; n++) begin
      ri = mk(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], 1'b1, 1'b1,
              pool[$urandom_range(0, 4)], 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      issue(ri);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
